// File: rtl/req2send_rsp.sv
// rtl/req2send_rsp.sv - request/ack responder with latency control and FWFT output FIFO
module req2send_rsp #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int ACK_LAT = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   request,
  input  logic [DW-1:0]          data_in,
  output logic                   ack,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Counter preload so ack lands exactly ACK_LAT edges after the sampling edge.
  localparam logic [3:0] LAT_M1 = (ACK_LAT > 0) ? 4'(ACK_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;
  logic            can_wr;

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign can_wr     = (count_q < CW'(DEPTH)) || pop;
  assign ack        = (state_q == S_ACK);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign proto_err  = err_q;

  // Handshake FSM next-state, latency countdown, error flag and push decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (request) begin
          if (ACK_LAT == 0) begin
            if (can_wr) begin
              push    = 1'b1;
              state_d = S_ACK;
            end else begin
              cnt_d   = 4'd0;
              state_d = S_DELAY;
            end
          end else begin
            cnt_d   = LAT_M1;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (!request) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (can_wr) begin
          push    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!request) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, latency counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; stale words are never visible because out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_req2send_rsp.sv
// tb/tb_req2send_rsp.sv - directed vector bench for req2send_rsp at three ack latencies
module tb_req2send_rsp;

  logic       clk;
  logic [2:0] rstn;
  logic [2:0] req;
  logic [2:0] rdy;
  logic [7:0] din  [3];
  logic [2:0] ack;
  logic [2:0] ov;
  logic [2:0] perr;
  logic [7:0] od   [3];
  logic [2:0] cnt  [3];

  int n_chk;
  int n_fail;

  typedef struct {
    logic       req;
    logic [7:0] din;
    logic       rdy;
    logic       e_ack;
    logic       e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  req2send_rsp #(.DW(8), .DEPTH(4), .ACK_LAT(0)) u_lat0 (
    .clk(clk), .reset_n(rstn[0]), .request(req[0]), .data_in(din[0]),
    .ack(ack[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
    .fifo_count(cnt[0]), .proto_err(perr[0])
  );

  req2send_rsp #(.DW(8), .DEPTH(4), .ACK_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(rstn[1]), .request(req[1]), .data_in(din[1]),
    .ack(ack[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
    .fifo_count(cnt[1]), .proto_err(perr[1])
  );

  req2send_rsp #(.DW(8), .DEPTH(4), .ACK_LAT(4)) u_lat4 (
    .clk(clk), .reset_n(rstn[2]), .request(req[2]), .data_in(din[2]),
    .ack(ack[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
    .fifo_count(cnt[2]), .proto_err(perr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until ack is seen, counting the sampling edge; bounded by maxc.
  task automatic wait_ack(input int idx, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack[idx] && n < maxc);
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] d, input logic rd,
                              input logic ea, input logic ev, input logic [7:0] eo,
                              input logic [2:0] ec);
    vec_t v;
    v.req = r; v.din = d; v.rdy = rd;
    v.e_ack = ea; v.e_ov = ev; v.e_od = eo; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;

    // Single word, then fill to full with out_ready low, backpressure, push+pop, drain with wrap.
    tbl.push_back(mk(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 3'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0));
    for (int k = 1; k <= 4; k++) begin
      tbl.push_back(mk(1'b1, 8'(k), 1'b0, 1'b1, 1'b1, 8'h01, 3'(k)));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'(k)));
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'(k)));
    end
    tbl.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4));
    tbl.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4));
    tbl.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4));
    tbl.push_back(mk(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3'd4));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd4));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd4));
    tbl.push_back(mk(1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03, 3'd4));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd3));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 3'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 3'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0));

    rstn = 3'b000;
    req  = 3'b000;
    rdy  = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    tick(2);
    chk("reset ack", int'(ack[0]), 0);
    chk("reset out_valid", int'(ov[0]), 0);
    chk("reset fifo_count", int'(cnt[0]), 0);
    chk("reset proto_err", int'(perr[0]), 0);
    chk("reset out_data", int'(od[0]), 0);
    rstn = 3'b111;

    foreach (tbl[i]) begin
      req[0] = tbl[i].req;
      din[0] = tbl[i].din;
      rdy[0] = tbl[i].rdy;
      tick(1);
      chk($sformatf("vec%0d ack", i), int'(ack[0]), int'(tbl[i].e_ack));
      chk($sformatf("vec%0d out_valid", i), int'(ov[0]), int'(tbl[i].e_ov));
      chk($sformatf("vec%0d out_data", i), int'(od[0]), int'(tbl[i].e_od));
      chk($sformatf("vec%0d fifo_count", i), int'(cnt[0]), int'(tbl[i].e_cnt));
    end
    chk("lat0 proto_err clean", int'(perr[0]), 0);

    // ACK_LAT=3: ack three edges after the sampling edge, then no re-accept while request stays high.
    req[1] = 1'b1; din[1] = 8'hC3; rdy[1] = 1'b0;
    wait_ack(1, 20, n);
    chk("lat3 ack seen", int'(ack[1]), 1);
    chk("lat3 edges to ack", n, 4);
    chk("lat3 out_data", int'(od[1]), 8'hC3);
    chk("lat3 fifo_count", int'(cnt[1]), 1);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("lat3 hold%0d ack", i), int'(ack[1]), 0);
      chk($sformatf("lat3 hold%0d fifo_count", i), int'(cnt[1]), 1);
    end
    req[1] = 1'b0;
    tick(2);
    req[1] = 1'b1; din[1] = 8'h11;
    wait_ack(1, 20, n);
    chk("lat3 second edges to ack", n, 4);
    req[1] = 1'b0;
    tick(2);
    chk("lat3 two stored", int'(cnt[1]), 2);

    // Reset while in DELAY with two words stored; pending word must not be captured.
    req[1] = 1'b1; din[1] = 8'h22;
    tick(2);
    chk("lat3 delay no ack", int'(ack[1]), 0);
    rstn[1] = 1'b0; req[1] = 1'b0;
    tick(1);
    chk("midreset ack", int'(ack[1]), 0);
    chk("midreset out_valid", int'(ov[1]), 0);
    chk("midreset fifo_count", int'(cnt[1]), 0);
    chk("midreset out_data", int'(od[1]), 0);
    chk("midreset proto_err", int'(perr[1]), 0);
    rstn[1] = 1'b1;
    tick(2);
    chk("postreset fifo_count", int'(cnt[1]), 0);
    req[1] = 1'b1; din[1] = 8'h33;
    wait_ack(1, 20, n);
    chk("postreset edges to ack", n, 4);
    chk("postreset out_data", int'(od[1]), 8'h33);
    chk("postreset fifo_count1", int'(cnt[1]), 1);
    req[1] = 1'b0;
    tick(2);

    // ACK_LAT=4: request dropped after two cycles in DELAY flags a sticky error.
    req[2] = 1'b1; din[2] = 8'hAA; rdy[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("lat4 delay%0d ack", i), int'(ack[2]), 0);
    end
    req[2] = 1'b0;
    tick(1);
    chk("protoerr set", int'(perr[2]), 1);
    chk("protoerr no ack", int'(ack[2]), 0);
    chk("protoerr fifo_count", int'(cnt[2]), 0);
    tick(2);
    chk("protoerr sticky", int'(perr[2]), 1);
    req[2] = 1'b1; din[2] = 8'hBB;
    wait_ack(2, 20, n);
    chk("lat4 edges to ack", n, 5);
    chk("lat4 out_data", int'(od[2]), 8'hBB);
    chk("lat4 fifo_count", int'(cnt[2]), 1);
    chk("lat4 proto_err kept", int'(perr[2]), 1);
    req[2] = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
